// File: rtl/score_pkg.sv
// Shared types and constants for the score display path: score range, FSM states,
// digit-enable codes and 7-segment glyphs (bit0=a ... bit6=g, active-high).
package score_pkg;

    localparam int               SCORE_BW  = 7;
    localparam logic [6:0]       SCORE_MAX = 7'd99;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_e;

    localparam logic [1:0] DIG_ONES = 2'b01;
    localparam logic [1:0] DIG_TENS = 2'b10;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD digit to 7-segment pattern; non-decimal nibbles go dark.
module seg_decoder
    import score_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display.sv
// Binary score -> two BCD digits (sequential double-dabble) -> multiplexed 7-segment drive.
// Optional macro LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module score_display
    import score_pkg::*;
#(
    parameter int BW          = SCORE_BW,
    parameter int REFRESH_DIV = 1000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [BW-1:0] value_i,
    output logic          busy_o,
    output logic [3:0]    bcd_tens_o,
    output logic [3:0]    bcd_ones_o,
    output logic [6:0]    seg_o,
    output logic [1:0]    dig_en_o
);

    localparam int                CNT_W    = $clog2(BW + 1);
    localparam int                SR_W     = 8 + BW;
    localparam int                REF_W    = 16;
    localparam logic [REF_W-1:0]  REF_LAST = REF_W'(REFRESH_DIV - 1);

    function automatic logic [BW-1:0] clamp(input logic [BW-1:0] v);
        return (v > BW'(SCORE_MAX)) ? BW'(SCORE_MAX) : v;
    endfunction

    // Nibble correction on the two BCD digits, then shift the whole register left.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] t;
        t = sr;
        if (t[SR_W-1 -: 4] >= 4'd5) t[SR_W-1 -: 4] = t[SR_W-1 -: 4] + 4'd3;
        if (t[SR_W-5 -: 4] >= 4'd5) t[SR_W-5 -: 4] = t[SR_W-5 -: 4] + 4'd3;
        return {t[SR_W-2:0], 1'b0};
    endfunction

    state_e           state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BW-1:0]    last_q, last_d;
    logic             pending_q, pending_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic [REF_W-1:0] ref_q, ref_d;
    logic [1:0]       dig_q, dig_d;
    logic [6:0]       seg_q, seg_d;
    logic [BW-1:0]    value_c;
    logic [3:0]       mux_digit;
    logic [6:0]       seg_dec;

    assign value_c = clamp(value_i);

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        pending_d = pending_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        case (state_q)
            IDLE: begin
                if (pending_q || (value_c != last_q)) begin
                    sr_d      = {8'd0, value_c};
                    last_d    = value_c;
                    pending_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = dabble_step(sr_q);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BW - 1)) state_d = LOAD;
            end
            LOAD: begin
                tens_d  = sr_q[SR_W-1 -: 4];
                ones_d  = sr_q[SR_W-5 -: 4];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit multiplexer; seg is computed from next-state values so it never lags dig_en.
    always_comb begin
        ref_d = ref_q + REF_W'(1);
        dig_d = dig_q;
        if (ref_q == REF_LAST) begin
            ref_d = '0;
            dig_d = (dig_q == DIG_ONES) ? DIG_TENS : DIG_ONES;
        end
        mux_digit = (dig_d == DIG_TENS) ? tens_d : ones_d;
        seg_d     = seg_dec;
`ifdef LEADING_ZERO_BLANK_EN
        if ((dig_d == DIG_TENS) && (tens_d == 4'd0)) seg_d = SEG_BLANK;
`endif
    end

    seg_decoder u_seg_decoder (
        .digit_i (mux_digit),
        .seg_o   (seg_dec)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= '0;
            pending_q <= 1'b1;
            tens_q    <= '0;
            ones_q    <= '0;
            ref_q     <= '0;
            dig_q     <= DIG_ONES;
            seg_q     <= SEG_0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            pending_q <= pending_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            ref_q     <= ref_d;
            dig_q     <= dig_d;
            seg_q     <= seg_d;
        end
    end

    always_ff @(posedge clk_i) begin
        sr_q <= sr_d;
    end

    assign busy_o     = (state_q != IDLE);
    assign bcd_tens_o = tens_q;
    assign bcd_ones_o = ones_q;
    assign seg_o      = seg_q;
    assign dig_en_o   = dig_q;

endmodule
